bcd_count_7seg: RTL

Two-digit BCD event counter with built-in prescaler and seven-segment encoder; produces the packed 14-bit two-digit segment word consumed by the display multiplexer stage. It sits directly upstream of the multiplexer. It divides the system clock into count ticks, steps a 00–99 decimal value up or down, and drives registered segment patterns for both digits.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_count_7seg.sv | 85 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: digit patterns and the BCD-to-segment encoder.
// Segments are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

    // Non-BCD codes blank the digit.
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] bcd);
        logic [SEG_W-1:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = '0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of a BCD up/down counter. carry flags a step that rolls the digit over
// (9->0 counting up, 0->9 counting down) and drives the next decade's step.
module bcd_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       up,
    input  logic       clr,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q, digit_d;
    logic       at_limit;

    // Next digit: clear wins over step; roll over at the limit for the current direction.
    always_comb begin
        at_limit = up ? (digit_q == 4'd9) : (digit_q == 4'd0);
        carry    = step && at_limit;
        digit_d  = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (step) begin
            if (up) begin
                digit_d = at_limit ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = at_limit ? 4'd9 : digit_q - 4'd1;
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_count_7seg.sv
// Two-digit BCD event counter: prescaler, 00-99 up/down count, wrap pulse and
// registered two-digit segment word for the display multiplexer.
module bcd_count_7seg
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned CBITS    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up,
    input  logic                 clr,
    output logic [7:0]           value,
    output logic [2*SEG_W-1:0]   both7seg,
    output logic                 wrap
);

    localparam logic [CBITS-1:0] PCNT_LAST = CBITS'(TICK_DIV - 1);

    logic [CBITS-1:0]   pcnt_q, pcnt_d;
    logic               tick;
    logic [3:0]         ones, tens;
    logic               ones_carry, tens_carry;
    logic               wrap_q, wrap_d;
    logic [2*SEG_W-1:0] seg_q;

    // Prescaler next state: holds while disabled so a paused period resumes where it left off.
    always_comb begin
        tick   = en && (pcnt_q == PCNT_LAST);
        pcnt_d = pcnt_q;
        if (clr || tick) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = pcnt_q + CBITS'(1);
        end
        // A clear discards a coincident tick, so it must also suppress the wrap pulse.
        wrap_d = tens_carry && !clr;
    end

    bcd_digit u_ones (
        .clk   (clk),
        .rst   (rst),
        .step  (tick),
        .up    (up),
        .clr   (clr),
        .digit (ones),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .clk   (clk),
        .rst   (rst),
        .step  (ones_carry),
        .up    (up),
        .clr   (clr),
        .digit (tens),
        .carry (tens_carry)
    );

    // Prescaler, wrap pulse and segment registers; segments trail value by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            wrap_q <= 1'b0;
            seg_q  <= {SEG_0, SEG_0};
        end else begin
            pcnt_q <= pcnt_d;
            wrap_q <= wrap_d;
            seg_q  <= {bcd_to_seg(tens), bcd_to_seg(ones)};
        end
    end

    assign value    = {tens, ones};
    assign both7seg = seg_q;
    assign wrap     = wrap_q;

`ifdef FORMAL
    // A held clear would starve the prescaler, so liveness assumes it stays low.
    m_en_often: assume property (@(posedge clk) s_eventually en);
    m_no_clr:   assume property (@(posedge clk) !clr);
    a_live:     assert property (@(posedge clk) disable iff (rst) s_eventually tick);
`endif

endmodule
